intersection_phase_sequencer: RTL and testbench

- Timed phase sequencer for a two-street intersection: it drives lamp codes La/Lb through green/yellow/all-red phases.
- Enforces minimum green, fixed yellow and all-red dwell times, counted in external tick pulses.
- Arbitrates between street sensors (Ta, Tb), the parade hold M from the mode FSM, and latched pedestrian requests.
- Sits between the mode FSM and the lamp drivers, replacing the untimed light FSM.

---
 rtl/intersection_phase_sequencer_pkg.sv | 39 +++
 rtl/intersection_phase_sequencer_phase_timer.sv | 30 +++
 rtl/intersection_phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_intersection_phase_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_phase_sequencer_pkg.sv
// Shared phase codes, lamp encodings and phase-to-lamp helpers for the intersection sequencer.
package tl_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  localparam logic [PHASE_W-1:0] A_GRN = 3'd0;
  localparam logic [PHASE_W-1:0] A_YEL = 3'd1;
  localparam logic [PHASE_W-1:0] AR_AB = 3'd2;
  localparam logic [PHASE_W-1:0] B_GRN = 3'd3;
  localparam logic [PHASE_W-1:0] B_YEL = 3'd4;
  localparam logic [PHASE_W-1:0] AR_BA = 3'd5;
  localparam logic [PHASE_W-1:0] FLASH = 3'd6;

  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b111;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

  // Street A lamp on entry to a phase; FLASH starts on the amber half.
  function automatic logic [LAMP_W-1:0] lamp_a_of(input logic [PHASE_W-1:0] ph);
    case (ph)
      A_GRN:   lamp_a_of = LAMP_GRN;
      A_YEL:   lamp_a_of = LAMP_YEL;
      FLASH:   lamp_a_of = LAMP_YEL;
      default: lamp_a_of = LAMP_RED;
    endcase
  endfunction

  // Street B lamp on entry to a phase; FLASH starts on the red half.
  function automatic logic [LAMP_W-1:0] lamp_b_of(input logic [PHASE_W-1:0] ph);
    case (ph)
      B_GRN:   lamp_b_of = LAMP_GRN;
      B_YEL:   lamp_b_of = LAMP_YEL;
      default: lamp_b_of = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_phase_sequencer_phase_timer.sv
// Tick-enabled dwell down-counter: loads a duration-1 value, counts to zero, flags expiry.
module phase_timer #(
  parameter int unsigned       CNT_W   = 4,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (tick) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/intersection_phase_sequencer.sv
// Timed green/yellow/all-red phase sequencer with pedestrian latching.
// Optional night flashing mode is compiled in with NIGHT_FLASH_EN.
module intersection_phase_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        Ta,
  input  logic        Tb,
  input  logic        M,
  input  logic        ped_a,
  input  logic        ped_b,
`ifdef NIGHT_FLASH_EN
  input  logic        night,
`endif
  output logic [2:0]  La,
  output logic [2:0]  Lb,
  output logic [2:0]  phase,
  output logic        walk_a,
  output logic        walk_b
);

  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(ALLRED_T - 1);

  logic [PHASE_W-1:0] next_phase;
  logic [LAMP_W-1:0]  next_la;
  logic [LAMP_W-1:0]  next_lb;
  logic               next_walk_a;
  logic               next_walk_b;
  logic               pend_a;
  logic               pend_b;
  logic               next_pend_a;
  logic               next_pend_b;
  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic               expired;
  logic               night_req;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (GRN_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

`ifdef NIGHT_FLASH_EN
  // Night request is sticky until the flash phase is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      night_req <= 1'b0;
    end else if (night) begin
      night_req <= 1'b1;
    end else if (tick && phase == FLASH) begin
      night_req <= 1'b0;
    end
  end
`else
  assign night_req = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= A_GRN;
      La     <= LAMP_GRN;
      Lb     <= LAMP_RED;
      walk_a <= 1'b0;
      walk_b <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      phase  <= next_phase;
      La     <= next_la;
      Lb     <= next_lb;
      walk_a <= next_walk_a;
      walk_b <= next_walk_b;
      pend_a <= next_pend_a;
      pend_b <= next_pend_b;
    end
  end

  // Next phase, timer load, and the output values that follow the phase.
  always_comb begin
    next_phase  = phase;
    load        = 1'b0;
    load_val    = GRN_LD;
    next_la     = La;
    next_lb     = Lb;
    next_walk_a = walk_a;
    next_walk_b = walk_b;
    next_pend_a = pend_a;
    next_pend_b = pend_b;

    if (tick) begin
      case (phase)
        A_GRN: begin
          if (expired && (night_req || !Ta || M || pend_a)) begin
            next_phase = A_YEL;
            load       = 1'b1;
            load_val   = YEL_LD;
          end
        end
        A_YEL: begin
          if (expired) begin
            next_phase = AR_AB;
            load       = 1'b1;
            load_val   = AR_LD;
          end
        end
        AR_AB: begin
          if (expired) begin
            next_phase = night_req ? FLASH : B_GRN;
            load       = 1'b1;
            load_val   = GRN_LD;
          end
        end
        // Parade hold outranks street B traffic and pedestrian requests.
        B_GRN: begin
          if (expired && (night_req || (!M && (!Tb || pend_b)))) begin
            next_phase = B_YEL;
            load       = 1'b1;
            load_val   = YEL_LD;
          end
        end
        B_YEL: begin
          if (expired) begin
            next_phase = AR_BA;
            load       = 1'b1;
            load_val   = AR_LD;
          end
        end
        AR_BA: begin
          if (expired) begin
            next_phase = night_req ? FLASH : A_GRN;
            load       = 1'b1;
            load_val   = GRN_LD;
          end
        end
`ifdef NIGHT_FLASH_EN
        FLASH: begin
          if (!night) begin
            next_phase = AR_BA;
            load       = 1'b1;
            load_val   = AR_LD;
          end
        end
`endif
        default: begin
          next_phase = A_GRN;
          load       = 1'b1;
          load_val   = GRN_LD;
        end
      endcase
    end

    // Walk signals rise on entry to the serving green, not on reset.
    if (next_phase != phase) begin
      next_la     = lamp_a_of(next_phase);
      next_lb     = lamp_b_of(next_phase);
      next_walk_a = (next_phase == B_GRN);
      next_walk_b = (next_phase == A_GRN);
    end
`ifdef NIGHT_FLASH_EN
    else if (tick && phase == FLASH) begin
      next_la = (La == LAMP_YEL) ? LAMP_OFF : LAMP_YEL;
      next_lb = (Lb == LAMP_RED) ? LAMP_OFF : LAMP_RED;
    end
`endif

    // Entry into the serving green clears the request and beats a same-cycle arrival.
    if (next_phase == B_GRN && phase != B_GRN) begin
      next_pend_a = 1'b0;
    end else if (ped_a && phase != B_GRN) begin
      next_pend_a = 1'b1;
    end

    if (next_phase == A_GRN && phase != A_GRN) begin
      next_pend_b = 1'b0;
    end else if (ped_b && phase != A_GRN) begin
      next_pend_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_intersection_phase_sequencer.sv
// Scoreboard bench for intersection_phase_sequencer: random stimulus vs. a tick-age reference model.
module tb_intersection_phase_sequencer;

  localparam int unsigned GREEN_MIN = 4;
  localparam int unsigned YELLOW_T  = 2;
  localparam int unsigned ALLRED_T  = 1;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] la;
    logic [2:0] lb;
    logic       wa;
    logic       wb;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       Ta = 1'b0;
  logic       Tb = 1'b0;
  logic       M = 1'b0;
  logic       ped_a = 1'b0;
  logic       ped_b = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif
  logic [2:0] La;
  logic [2:0] Lb;
  logic [2:0] phase;
  logic       walk_a;
  logic       walk_b;

  intersection_phase_sequencer #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .CNT_W     (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .Ta     (Ta),
    .Tb     (Tb),
    .M      (M),
    .ped_a  (ped_a),
    .ped_b  (ped_b),
`ifdef NIGHT_FLASH_EN
    .night  (night),
`endif
    .La     (La),
    .Lb     (Lb),
    .phase  (phase),
    .walk_a (walk_a),
    .walk_b (walk_b)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  obs_t expq[$];

  // Reference model: phase number, ticks spent in phase, pending and walk flags.
  int m_phase = 0;
  int m_age   = 0;
  bit m_pa = 1'b0, m_pb = 1'b0, m_wa = 1'b0, m_wb = 1'b0;

  function automatic int dur(input int p);
    if (p == 0 || p == 3) return GREEN_MIN;
    if (p == 1 || p == 4) return YELLOW_T;
    return ALLRED_T;
  endfunction

  function automatic logic [2:0] lamp_a(input int p);
    if (p == 0) return 3'b111;
    if (p == 1) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [2:0] lamp_b(input int p);
    if (p == 3) return 3'b111;
    if (p == 4) return 3'b100;
    return 3'b001;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ph = 3'(m_phase);
    o.la = lamp_a(m_phase);
    o.lb = lamp_b(m_phase);
    o.wa = m_wa;
    o.wb = m_wb;
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_age = 0;
    m_pa = 1'b0; m_pb = 1'b0; m_wa = 1'b0; m_wb = 1'b0;
  endtask

  // One clock of the rules: a phase may end once it has seen its full dwell in ticks.
  task automatic model_clock(input bit tk, input bit ta, input bit tb, input bit m,
                             input bit pa, input bit pb);
    int nxt = m_phase;
    bit done = (m_age >= dur(m_phase) - 1);
    if (tk && done) begin
      case (m_phase)
        0: if (!ta || m || m_pa) nxt = 1;
        3: if (!m && (!tb || m_pb)) nxt = 4;
        default: nxt = (m_phase + 1) % 6;
      endcase
    end
    if (nxt == 3 && m_phase != 3) m_pa = 1'b0;
    else if (pa && m_phase != 3) m_pa = 1'b1;
    if (nxt == 0 && m_phase != 0) m_pb = 1'b0;
    else if (pb && m_phase != 0) m_pb = 1'b1;
    if (nxt != m_phase) begin
      m_wa  = (nxt == 3);
      m_wb  = (nxt == 0);
      m_age = 0;
    end else if (tk) begin
      m_age++;
    end
    m_phase = nxt;
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got ph=%0d La=%b Lb=%b wa=%b wb=%b, expected ph=%0d La=%b Lb=%b wa=%b wb=%b",
               name, cyc, got.ph, got.la, got.lb, got.wa, got.wb,
               exp.ph, exp.la, exp.lb, exp.wa, exp.wb);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.ph = phase; o.la = La; o.lb = Lb; o.wa = walk_a; o.wb = walk_b;
    return o;
  endfunction

  // Drive one clock of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic step(input bit ta, input bit tb, input bit m, input bit pa, input bit pb);
    bit tk;
    @(negedge clk);
    if (!rst) rst = 1'b1;
    tk = (cyc % 4 == 3);
    cyc++;
    tick = tk; Ta = ta; Tb = tb; M = m; ped_a = pa; ped_b = pb;
    model_clock(tk, ta, tb, m, pa, pb);
    expq.push_back(model_obs());
  endtask

  // Monitor: every queued expectation is compared just after the edge that produces it.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        compare("seq", dut_obs(), e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    int pta, ptb, pm, pped;

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare("reset_state", dut_obs(), model_obs());

    // Street A traffic keeps A green indefinitely.
    repeat (80) step(1, 0, 0, 0, 0);

    // Street A empties; run until B green is reached.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      found = (m_phase == 3);
    end
    if (!found) begin
      checks++; fails++;
      $display("FAIL reach_b_grn: got phase %0d, expected 3", m_phase);
    end

    // Parade hold with a pedestrian B request, then release.
    step(0, 0, 1, 0, 1);
    repeat (120) step(0, 0, 1, 0, 0);
    repeat (60) step(1, 1, 0, 0, 0);

    // Pedestrian A request forces A to yield despite traffic; a second one in B green is dropped.
    step(1, 0, 0, 1, 0);
    repeat (60) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, (m_phase == 3), 0);
    repeat (60) step(1, 0, 0, 0, 0);

    // Randomized segments with varying input biases.
    for (int s = 0; s < 12; s++) begin
      pta  = $urandom_range(1, 4);
      ptb  = $urandom_range(1, 4);
      pm   = $urandom_range(0, 3);
      pped = $urandom_range(8, 32);
      repeat (100)
        step(($urandom % 5) < pta, ($urandom % 5) < ptb, ($urandom % 8) < pm,
             ($urandom % pped) == 0, ($urandom % pped) == 0);
    end

    // Asynchronous reset in the middle of A yellow, between ticks, with a request pending.
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      step(0, 0, 0, (m_phase == 1), 0);
      n++;
      found = (m_phase == 1) && (cyc % 4 != 3);
    end
    if (!found) begin
      checks++; fails++;
      $display("FAIL reach_a_yel: got phase %0d, expected 1", m_phase);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    compare("async_reset", dut_obs(), model_obs());

    // After reset the cleared request must not shorten A green.
    repeat (80) step(1, 0, 0, 0, 0);
    repeat (40) step(0, 1, 0, 0, 0);

    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
